// File: rtl/spi_target_pkg.sv
// rtl/spi_target_pkg.sv - shared types and constants for the SPI mode-0 target
package spi_target_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_tgt_state_t;

  localparam logic [7:0] FILL_DEFAULT = 8'hFF;
  localparam int         SYNC_STAGES  = 2;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO, wrap-bit pointers
// A read while empty is ignored; a write while full is accepted only alongside a read.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/spi_target.sv
// rtl/spi_target.sv - oversampled SPI mode-0 target with RX/TX byte FIFOs
// Pins are synchronized to clk; all protocol decisions are made on detected edges.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int         DEPTH = 8,
  parameter logic [7:0] FILL  = FILL_DEFAULT
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       spi_sck,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] tx_din,
  input  logic       tx_wen,
  output logic       tx_full,
  output logic [7:0] rx_dout,
  input  logic       rx_ren,
  output logic       rx_data_present,
  output logic       rx_overflow,
  input  logic       ovf_clr,
  output logic       busy
);

  logic [SYNC_STAGES-1:0] sck_pipe;
  logic [SYNC_STAGES-1:0] cs_pipe;
  logic [SYNC_STAGES-1:0] mosi_pipe;
  logic                   sck_prev;
  logic                   cs_prev;
  logic                   sck_sync;
  logic                   cs_sync;
  logic                   mosi_sync;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   cs_rise;
  logic                   cs_fall;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      sck_pipe  <= '0;
      cs_pipe   <= '1;
      mosi_pipe <= '0;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], spi_sck};
      cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], spi_cs};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi};
      sck_prev  <= sck_sync;
      cs_prev   <= cs_sync;
    end
  end

  assign sck_sync  = sck_pipe[SYNC_STAGES-1];
  assign cs_sync   = cs_pipe[SYNC_STAGES-1];
  assign mosi_sync = mosi_pipe[SYNC_STAGES-1];
  assign sck_rise  = sck_sync && !sck_prev;
  assign sck_fall  = !sck_sync && sck_prev;
  assign cs_rise   = cs_sync && !cs_prev;
  assign cs_fall   = !cs_sync && cs_prev;

  logic       tx_pop;
  logic [7:0] tx_head;
  logic       tx_empty;
  logic       rx_push;
  logic [7:0] rx_byte;
  logic       rx_full;
  logic       rx_empty;
  logic [7:0] load_byte;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (Rst),
    .wr_en   (tx_wen),
    .wr_data (tx_din),
    .full    (tx_full),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .empty   (tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (Rst),
    .wr_en   (rx_push),
    .wr_data (rx_byte),
    .full    (rx_full),
    .rd_en   (rx_ren),
    .rd_data (rx_dout),
    .empty   (rx_empty)
  );

  assign rx_data_present = !rx_empty;
  assign load_byte       = tx_empty ? FILL : tx_head;

  spi_tgt_state_t state;
  spi_tgt_state_t state_n;
  logic [2:0]     bit_cnt;
  logic [2:0]     bit_cnt_n;
  logic [7:0]     rx_shift;
  logic [7:0]     rx_shift_n;
  logic [7:0]     tx_shift;
  logic [7:0]     tx_shift_n;
  logic           miso_q;
  logic           miso_n;
  logic           byte_done;
  logic           byte_done_n;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      miso_q    <= 1'b1;
      byte_done <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      rx_shift  <= rx_shift_n;
      tx_shift  <= tx_shift_n;
      miso_q    <= miso_n;
      byte_done <= byte_done_n;
    end
  end

  assign rx_byte = {rx_shift[6:0], mosi_sync};

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    rx_shift_n  = rx_shift;
    tx_shift_n  = tx_shift;
    miso_n      = miso_q;
    byte_done_n = byte_done;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;

    unique case (state)
      IDLE: begin
        miso_n = 1'b1;
        if (cs_fall) begin
          state_n     = ACTIVE;
          bit_cnt_n   = '0;
          tx_pop      = !tx_empty;
          tx_shift_n  = load_byte;
          miso_n      = load_byte[7];
          byte_done_n = 1'b0;
        end
      end
      ACTIVE: begin
        // CS edges pre-empt any SCK edge seen in the same cycle
        if (cs_rise) begin
          state_n     = IDLE;
          bit_cnt_n   = '0;
          miso_n      = 1'b1;
          byte_done_n = 1'b0;
        end else if (sck_rise) begin
          rx_shift_n  = rx_byte;
          bit_cnt_n   = bit_cnt + 3'd1;
          byte_done_n = (bit_cnt == 3'd7);
          if (bit_cnt == 3'd7) begin
            rx_push    = 1'b1;
            tx_pop     = !tx_empty;
            tx_shift_n = load_byte;
          end
        end else if (sck_fall) begin
          // After a reload the fresh MSB is already in place, so no shift
          if (byte_done) begin
            miso_n = tx_shift[7];
          end else begin
            tx_shift_n = {tx_shift[6:0], 1'b0};
            miso_n     = tx_shift[6];
          end
          byte_done_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      rx_overflow <= 1'b0;
    end else if (rx_push && rx_full && !rx_ren) begin
      rx_overflow <= 1'b1;
    end else if (ovf_clr) begin
      rx_overflow <= 1'b0;
    end
  end

  assign spi_miso = miso_q;
  assign busy     = (state == ACTIVE);

endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - directed self-checking bench for spi_target
module tb_spi_target;

  localparam int HALF  = 8;
  localparam int SETUP = 8;

  logic       clk = 1'b0;
  logic       Rst;
  logic       spi_sck;
  logic       spi_cs;
  logic       spi_mosi;
  logic       spi_miso;
  logic [7:0] tx_din;
  logic       tx_wen;
  logic       tx_full;
  logic [7:0] rx_dout;
  logic       rx_ren;
  logic       rx_data_present;
  logic       rx_overflow;
  logic       ovf_clr;
  logic       busy;

  int checks = 0;
  int errors = 0;

  spi_target #(.DEPTH(8), .FILL(8'hFF)) dut (
    .clk             (clk),
    .Rst             (Rst),
    .spi_sck         (spi_sck),
    .spi_cs          (spi_cs),
    .spi_mosi        (spi_mosi),
    .spi_miso        (spi_miso),
    .tx_din          (tx_din),
    .tx_wen          (tx_wen),
    .tx_full         (tx_full),
    .rx_dout         (rx_dout),
    .rx_ren          (rx_ren),
    .rx_data_present (rx_data_present),
    .rx_overflow     (rx_overflow),
    .ovf_clr         (ovf_clr),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] d);
    @(negedge clk);
    tx_din = d;
    tx_wen = 1'b1;
    @(negedge clk);
    tx_wen = 1'b0;
  endtask

  task automatic rx_pop();
    @(negedge clk);
    rx_ren = 1'b1;
    @(negedge clk);
    rx_ren = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs = 1'b0;
    wait_clks(SETUP);
  endtask

  task automatic cs_high();
    wait_clks(SETUP);
    spi_cs = 1'b1;
    wait_clks(SETUP);
  endtask

  // Holds rx_ren for exactly the cycle in which the target pushes a byte
  task automatic ren_on_push();
    bit found = 1'b0;
    for (int k = 0; k < HALF && !found; k++) begin
      @(negedge clk);
      if (dut.rx_push) begin
        found  = 1'b1;
        rx_ren = 1'b1;
        @(negedge clk);
        rx_ren = 1'b0;
      end
    end
    chk("ren_push_seen", {31'd0, found}, 32'd1);
  endtask

  task automatic spi_byte(input logic [7:0] mo, input bit pulse_ren, output logic [7:0] mi);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = mo[i];
      wait_clks(HALF);
      mi[i]   = spi_miso;
      spi_sck = 1'b1;
      if (i == 0 && pulse_ren) ren_on_push();
      wait_clks(HALF);
      spi_sck = 1'b0;
    end
  endtask

  logic [7:0] mi;
  bit         seen;

  initial begin
    Rst = 1'b1; spi_sck = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
    tx_din = 8'h00; tx_wen = 1'b0; rx_ren = 1'b0; ovf_clr = 1'b0;
    wait_clks(3);
    Rst = 1'b0;
    wait_clks(2);

    chk("rst_miso", {31'd0, spi_miso}, 32'd1);
    chk("rst_tx_full", {31'd0, tx_full}, 32'd0);
    chk("rst_rx_present", {31'd0, rx_data_present}, 32'd0);
    chk("rst_rx_dout", {24'd0, rx_dout}, 32'h00);
    chk("rst_overflow", {31'd0, rx_overflow}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // TX preload: two queued bytes go out while two bytes come in
    tx_write(8'hA5);
    tx_write(8'h3C);
    cs_low();
    chk("pre_busy", {31'd0, busy}, 32'd1);
    spi_byte(8'h12, 1'b0, mi);
    chk("pre_miso0", {24'd0, mi}, 32'hA5);
    spi_byte(8'h34, 1'b0, mi);
    chk("pre_miso1", {24'd0, mi}, 32'h3C);
    cs_high();
    chk("pre_idle_busy", {31'd0, busy}, 32'd0);
    chk("pre_idle_miso", {31'd0, spi_miso}, 32'd1);
    chk("pre_tx_full", {31'd0, tx_full}, 32'd0);
    chk("pre_rx0", {24'd0, rx_dout}, 32'h12);
    rx_pop();
    chk("pre_rx1", {24'd0, rx_dout}, 32'h34);
    rx_pop();
    chk("pre_rx_empty", {31'd0, rx_data_present}, 32'd0);

    // TX empty sends the fill byte
    cs_low();
    spi_byte(8'h55, 1'b0, mi);
    cs_high();
    chk("fill_miso", {24'd0, mi}, 32'hFF);
    chk("fill_rx", {24'd0, rx_dout}, 32'h55);
    rx_pop();

    // CS abort after five SCK edges
    cs_low();
    spi_mosi = 1'b1;
    wait_clks(HALF);
    for (int e = 0; e < 5; e++) begin
      spi_sck = ~spi_sck;
      wait_clks(HALF);
    end
    wait_clks(SETUP);
    spi_cs = 1'b1;
    wait_clks(4);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_miso", {31'd0, spi_miso}, 32'd1);
    chk("abort_no_push", {31'd0, rx_data_present}, 32'd0);
    spi_sck = 1'b0;
    wait_clks(HALF);
    cs_low();
    spi_byte(8'hA7, 1'b0, mi);
    cs_high();
    chk("abort_next_rx", {24'd0, rx_dout}, 32'hA7);
    chk("abort_next_miso", {24'd0, mi}, 32'hFF);
    rx_pop();

    // RX overflow: nine bytes into an eight-deep FIFO
    cs_low();
    for (int b = 0; b < 9; b++) spi_byte(8'h10 + 8'(b), 1'b0, mi);
    cs_high();
    chk("ovf_set", {31'd0, rx_overflow}, 32'd1);
    for (int b = 0; b < 8; b++) begin
      chk("ovf_rx_data", {24'd0, rx_dout}, 32'h10 + 32'(b));
      rx_pop();
    end
    chk("ovf_rx_drained", {31'd0, rx_data_present}, 32'd0);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk("ovf_cleared", {31'd0, rx_overflow}, 32'd0);

    // Same again, but a read coincides with the ninth push
    cs_low();
    for (int b = 0; b < 9; b++) spi_byte(8'h20 + 8'(b), (b == 8), mi);
    cs_high();
    chk("ovf_ren_none", {31'd0, rx_overflow}, 32'd0);
    for (int b = 1; b < 9; b++) begin
      chk("ovf_ren_data", {24'd0, rx_dout}, 32'h20 + 32'(b));
      rx_pop();
    end
    chk("ovf_ren_drained", {31'd0, rx_data_present}, 32'd0);

    // TX write while full, coinciding with the byte-start pop
    for (int b = 0; b < 8; b++) tx_write(8'hC0 + 8'(b));
    chk("conc_full_before", {31'd0, tx_full}, 32'd1);
    @(negedge clk);
    spi_cs = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < SETUP && !seen; k++) begin
      @(negedge clk);
      if (dut.tx_pop) begin
        seen   = 1'b1;
        tx_din = 8'hEE;
        tx_wen = 1'b1;
        @(negedge clk);
        tx_wen = 1'b0;
      end
    end
    chk("conc_pop_seen", {31'd0, seen}, 32'd1);
    wait_clks(SETUP);
    chk("conc_full_after", {31'd0, tx_full}, 32'd1);
    for (int b = 0; b < 9; b++) begin
      spi_byte(8'(b), 1'b0, mi);
      chk("conc_miso", {24'd0, mi}, (b < 8) ? (32'hC0 + 32'(b)) : 32'hEE);
      if (b < 8) rx_pop();
    end
    cs_high();
    chk("conc_rx_left", {31'd0, rx_data_present}, 32'd1);

    // Reset mid-byte with both FIFOs holding data
    for (int b = 0; b < 8; b++) tx_write(8'h60 + 8'(b));
    cs_low();
    tx_write(8'h99);
    chk("rstmid_tx_full", {31'd0, tx_full}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      spi_mosi = 1'b1;
      wait_clks(HALF);
      spi_sck = 1'b1;
      wait_clks(HALF);
      spi_sck = 1'b0;
    end
    @(negedge clk);
    #2;
    Rst = 1'b1;
    #1;
    chk("rstmid_miso", {31'd0, spi_miso}, 32'd1);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_tx_full0", {31'd0, tx_full}, 32'd0);
    chk("rstmid_rx_present", {31'd0, rx_data_present}, 32'd0);
    chk("rstmid_rx_dout", {24'd0, rx_dout}, 32'h00);
    chk("rstmid_overflow", {31'd0, rx_overflow}, 32'd0);
    spi_cs = 1'b1;
    spi_sck = 1'b0;
    wait_clks(3);
    Rst = 1'b0;
    wait_clks(4);
    tx_write(8'h5A);
    cs_low();
    spi_byte(8'h3C, 1'b0, mi);
    cs_high();
    chk("post_rst_miso", {24'd0, mi}, 32'h5A);
    chk("post_rst_rx", {24'd0, rx_dout}, 32'h3C);
    rx_pop();
    chk("post_rst_empty", {31'd0, rx_data_present}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_target.md
# spi_target

SPI mode-0 target (responder) on the far end of the `spi_controller` SPI master interface. It runs on the system clock, oversamples `spi_sck`/`spi_cs`/`spi_mosi`, and deserializes MOSI bytes into an RX FIFO. It serializes bytes from a TX FIFO onto MISO. It is used as an on-chip loopback/emulation peer for the SPI master and exposes a `uart_controller`-style byte port to its local host.

## Interface
- `DEPTH`, 8: entries per FIFO (power of 2, ≥2)
- `FILL`, 8'hFF: byte shifted out when the TX FIFO is empty at byte start
- `clk` input 1: system clock
- `Rst` input 1: reset, asynchronous and active-high
- `spi_sck` input 1: SPI clock from master (asynchronous)
- `spi_cs` input 1: chip select, active-low (asynchronous)
- `spi_mosi` input 1: master-out data (asynchronous)
- `spi_miso` output 1: target-out data
- `tx_din` input 8: byte to transmit
- `tx_wen` input 1: push `tx_din` into the TX FIFO
- `tx_full` output 1: TX FIFO full
- `rx_dout` output 8: head of RX FIFO, first-word-fall-through
- `rx_ren` input 1: pop the RX FIFO
- `rx_data_present` output 1: RX FIFO non-empty
- `rx_overflow` output 1: sticky, a received byte was dropped
- `ovf_clr` input 1: clear `rx_overflow`
- `busy` output 1: transfer in progress (CS asserted)

## Operation
- `spi_sck`, `spi_cs`, and `spi_mosi` each pass through a 2-FF synchronizer. Edge detection compares the synchronized value with a third register.
- Mode 0 behaviour: MSB first. MOSI is sampled on the SCK rising edge. MISO changes on the SCK falling edge.
- The FSM has two states, IDLE and ACTIVE. It also keeps a 3-bit bit counter, an 8-bit RX shift register, and an 8-bit TX shift register.
- IDLE → ACTIVE on a synchronized CS falling edge:
  - bit counter := 0
  - TX shift register := TX FIFO head (popped), or `FILL` if the TX FIFO is empty
  - `spi_miso` := MSB of the TX shift register
- ACTIVE, SCK rising edge:
  - RX shift register := {rx[6:0], mosi_sync}
  - bit counter += 1, wrapping 7→0
- ACTIVE, SCK rising edge when the bit counter is 7 (byte complete):
  - push {rx[6:0], mosi_sync} into the RX FIFO
  - reload the TX shift register from the TX FIFO head (pop), or `FILL` if empty
- ACTIVE, SCK falling edge:
  - if the last rising edge did not complete a byte, shift the TX register left
  - `spi_miso` := new MSB
  - the first falling edge after a byte completion drives the MSB of the newly loaded byte
- ACTIVE → IDLE on a synchronized CS rising edge:
  - any partial RX byte is discarded
  - the popped TX byte is lost
  - bit counter := 0
  - `spi_miso` := 1
- In IDLE, `spi_miso` is held at 1 and SCK edges are ignored.
- RX push while the RX FIFO is full and `rx_ren` is low: the byte is dropped and `rx_overflow` is set.
  - If `rx_ren` is high in the same cycle, the push is accepted.
- `ovf_clr` clears `rx_overflow`. If `ovf_clr` and a new overflow occur in the same cycle, the flag is set (set wins).
- `tx_wen` while `tx_full` is high is ignored. A simultaneous TX pop frees space, so the write is accepted.
- `rx_ren` while empty is ignored. `rx_dout` reads 8'h00 when empty.
- A CS edge and an SCK edge detected in the same cycle: the CS edge takes priority and the SCK edge is ignored.

## Timing
- Reset values:
  - `spi_miso` = 1
  - `tx_full` = 0
  - `rx_data_present` = 0
  - `rx_dout` = 8'h00
  - `rx_overflow` = 0
  - `busy` = 0
  - state = IDLE
  - FIFOs empty
  - synchronizers hold SCK = 0 and CS = 1
- Asserting `Rst` mid-transfer aborts immediately, including the partial byte.
- Pin-to-detect latency is 3 `clk` edges. `spi_miso` updates on the cycle after detection.
- SCK high and low phases must each be ≥ 4 `clk` periods. CS setup and hold to the first and last SCK edge must be ≥ 4 `clk` periods.
- RX FIFO push to `rx_data_present`/`rx_dout` valid: 1 cycle.
- `tx_wen` to the FIFO head being available for a load: 1 cycle.
- `busy` = (state == ACTIVE).

## Structure
- `spi_target_pkg` holds:
  - the state enum `spi_tgt_state_t` {IDLE, ACTIVE}
  - the default `FILL` constant
  - the synchronizer depth constant (2)
- Sub-module `sync_fifo #(WIDTH, DEPTH)`:
  - FWFT read, one instance each for RX and TX
  - simultaneous read/write allowed when full or empty
  - `full`/`empty` flags derived from pointers with an extra wrap bit

## Test plan
- TX preload: write 8'hA5 and 8'h3C, then master clocks 16 bits with MOSI = 8'h12, 8'h34 → MISO bytes 8'hA5, 8'h3C; RX FIFO holds 8'h12, 8'h34; `tx_full` = 0 after.
- TX empty: master clocks 1 byte with MOSI = 8'h55 → MISO = 8'hFF (`FILL`); RX head = 8'h55.
- CS abort: CS rises after 5 SCK edges → no RX push, `busy` drops within 4 cycles, `spi_miso` = 1. The next full byte is received correctly.
- RX overflow: with `DEPTH` = 8, send 9 bytes without reads → 8 stored, `rx_overflow` = 1. Pulsing `ovf_clr` clears it. Repeating with `rx_ren` pulsed on the 9th push → no overflow.
- FIFO concurrency: `tx_wen` while full in the same cycle as a byte-start pop → write accepted, count unchanged.
- Reset mid-byte: assert `Rst` after 3 bits → all outputs return to reset values asynchronously. The following transfer is clean.
